tx_framer: RTL and testbench
============================

# tx_framer

Bit-level transmit framer sitting directly upstream of the BPSK mixer. It accepts payload bytes over a valid/ready handshake, builds a frame (preamble, sync word, length, payload, tail), and serializes it MSB-first at the bit rate. It drives the mixer's `data`, `mod_ena` and bit-rate clock `clk_data`. The bit clock is generated internally from the 2 MHz system clock.

## Interface
- `CLK_DIV`, 833: `clk` cycles per bit (2 MHz / 833 ≈ 2400 bit/s); must be ≥ 4.
- `PREAMBLE_BITS`, 32: number of alternating preamble bits.
- `SYNC_WORD`, 16'hEB90: 16-bit sync word, sent MSB first.
- `TAIL_BITS`, 8: number of trailing zero bits.
- `clk`  in  1  system clock, 2 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `len`  in  8  payload byte count; latched with `start`; 0 is legal.
- `tx_byte`  in  8  payload byte.
- `byte_valid`  in  1  `tx_byte` is valid.
- `byte_ready`  out  1  framer can accept a byte; transfer happens when `byte_valid & byte_ready`.
- `clk_data`  out  1  bit-rate clock to the mixer. It rises at each bit boundary.
- `data`  out  1  current transmitted bit.
- `mod_ena`  out  1  high for the full duration of the frame.
- `busy`  out  1  high while not IDLE.
- `underrun`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- FSM states: IDLE → PRE → SYNC → LEN → DATA → TAIL → IDLE.
- PRE: `PREAMBLE_BITS` bits, alternating, starting with 1.
- SYNC: 16 bits of `SYNC_WORD`.
- LEN: 8 bits of the latched `len`.
- DATA: `len` bytes, each sent MSB first.
- TAIL: `TAIL_BITS` zeros.
- If `len`==0, LEN goes directly to TAIL and `byte_ready` is never asserted.
- Bit counter `cnt` runs 0..`CLK_DIV`-1. A bit boundary occurs at `cnt`==0, when the next bit is loaded.
- `clk_data` = 1 while `cnt` < `CLK_DIV`/2 (integer division), otherwise 0.
- Prefetch register holds one byte.
  - `byte_ready` rises at the boundary that starts the last bit of the preceding field: LEN bit 0, or bit 0 of the current payload byte.
  - It falls on handshake, and never rises when no further byte is owed.
- Underrun: no handshake by `cnt`==`CLK_DIV`-1 of that bit. The framer then:
  - drives `underrun`=1 for one cycle;
  - returns to IDLE;
  - clears `mod_ena`, `busy`, `data`, `clk_data` and `byte_ready`.
- `start` while busy is ignored. `len`/`start` changes mid-frame have no effect.

## Timing
- Reset (async assert, sync release): every output is 0, the FSM is in IDLE and `cnt`=0.
- `start`=1 sampled in IDLE at edge t. At t+1:
  - `busy`=1, `mod_ena`=1;
  - `cnt`=0, `clk_data`=1;
  - `data`=first preamble bit (1).
- Each bit lasts exactly `CLK_DIV` cycles. `data` changes only on the cycle `clk_data` rises.
- Frame length = (`PREAMBLE_BITS`+16+8+8·`len`+`TAIL_BITS`)·`CLK_DIV` cycles of `mod_ena`=1.
- After the last tail bit's final cycle, the next edge returns the FSM to IDLE, and all outputs return to 0 in that same cycle.
- A new `start` is accepted on the cycle after `busy` falls.
- Reset asserted mid-frame: outputs go to 0 immediately, with no `underrun` pulse.

## Configuration
- `TX_FRAMER_DIFF_EN` defined: differential encoding is applied to every frame bit (preamble through tail).
  - `data`_k = `data`_{k-1} XOR b_k.
  - The reference bit is 0 at frame start.
  - This resolves the BPSK 180° ambiguity at the receiver.
- Undefined: `data` = b_k, with no encoder logic.

## Test plan
- Nominal frame: `CLK_DIV`=8, `len`=1, `tx_byte`=0xA5 presented immediately.
  - `mod_ena` high for exactly 72·8=576 cycles.
  - Bit sequence: 1010… (×32), EB90, 01, A5, 00.
  - `byte_ready` rises exactly once.
- Zero length: `len`=0 → frame of 64 bits, LEN field 00, `byte_ready` stays 0, `busy` falls after 512 cycles.
- Underrun: `len`=2, first byte supplied, `byte_valid` held 0 for the second.
  - `underrun` pulses at `cnt`==7 of the last bit of byte 1.
  - The next cycle has `mod_ena`=0, `busy`=0.
- Start while busy: pulse `start` with `len`=5 during SYNC → ignored; the frame completes with the original length. A `start` on the cycle after `busy` falls begins a new frame.
- Reset mid-DATA: drop `rst_n` at any cycle → all outputs 0 in the same cycle, no `underrun` pulse. After release, a normal frame transmits correctly.
- Differential mode (`TX_FRAMER_DIFF_EN`): preamble 1010… produces `data` 1100110011…. Decoding the output recovers the nominal-frame bit sequence.

Source files
------------

// File: rtl/tx_framer.sv
// Bit-level transmit framer: preamble, sync word, length, payload, tail, serialized MSB-first.
// Define TX_FRAMER_DIFF_EN to differentially encode every frame bit (reference 0 at frame start).
module tx_framer #(
   parameter int unsigned CLK_DIV       = 833,
   parameter int unsigned PREAMBLE_BITS = 32,
   parameter logic [15:0] SYNC_WORD     = 16'hEB90,
   parameter int unsigned TAIL_BITS     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] len,
   input  logic [7:0] tx_byte,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       clk_data,
   output logic       data,
   output logic       mod_ena,
   output logic       busy,
   output logic       underrun
);

   localparam int unsigned CNT_W   = $clog2(CLK_DIV);
   localparam int unsigned FLD_MAX = (PREAMBLE_BITS > TAIL_BITS)
                                     ? ((PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16)
                                     : ((TAIL_BITS > 16) ? TAIL_BITS : 16);
   localparam int unsigned IDX_W   = $clog2(FLD_MAX);

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEADLINE = CNT_W'(CLK_DIV - 2);
   localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(CLK_DIV / 2);
   localparam logic [IDX_W-1:0] PRE_LAST     = IDX_W'(PREAMBLE_BITS - 1);
   localparam logic [IDX_W-1:0] SYNC_LAST    = IDX_W'(15);
   localparam logic [IDX_W-1:0] BYTE_PENULT  = IDX_W'(6);
   localparam logic [IDX_W-1:0] BYTE_LAST    = IDX_W'(7);
   localparam logic [IDX_W-1:0] TAIL_LAST    = IDX_W'(TAIL_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_LEN, S_DATA, S_TAIL} state_t;

   state_t           r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [IDX_W-1:0] r_idx, w_idx;
   logic [14:0]      r_sh, w_sh;
   logic [7:0]       r_len, w_len;
   logic [7:0]       r_left, w_left;
   logic [7:0]       r_pf, w_pf;
   logic             r_pf_full, w_pf_full;
   logic             r_ready, w_ready;
   logic             r_underrun, w_underrun;
   logic             r_data, w_data;
   logic             w_bit, w_load, w_hs, w_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_sh       <= '0;
         r_len      <= '0;
         r_left     <= '0;
         r_pf       <= '0;
         r_pf_full  <= 1'b0;
         r_ready    <= 1'b0;
         r_underrun <= 1'b0;
         r_data     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_idx      <= w_idx;
         r_sh       <= w_sh;
         r_len      <= w_len;
         r_left     <= w_left;
         r_pf       <= w_pf;
         r_pf_full  <= w_pf_full;
         r_ready    <= w_ready;
         r_underrun <= w_underrun;
         r_data     <= w_data;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_idx      = r_idx;
      w_sh       = r_sh;
      w_len      = r_len;
      w_left     = r_left;
      w_pf       = r_pf;
      w_pf_full  = r_pf_full;
      w_ready    = r_ready;
      w_underrun = 1'b0;
      w_data     = r_data;
      w_bit      = 1'b0;
      w_load     = 1'b0;
      w_hs       = r_ready & byte_valid;

      if (r_state == S_IDLE) begin
         if (start) begin
            w_state   = S_PRE;
            w_cnt     = '0;
            w_idx     = '0;
            w_len     = len;
            w_left    = len;
            w_pf_full = 1'b0;
            w_ready   = 1'b0;
            w_bit     = 1'b1;
            w_load    = 1'b1;
         end
      end else if (r_underrun) begin
         w_state   = S_IDLE;
         w_cnt     = '0;
         w_idx     = '0;
         w_ready   = 1'b0;
         w_pf_full = 1'b0;
         w_data    = 1'b0;
      end else begin
         // A byte must be taken by the second-to-last cycle of its window, else the frame aborts
         if (w_hs) begin
            w_pf      = tx_byte;
            w_pf_full = 1'b1;
            w_ready   = 1'b0;
            w_left    = r_left - 1'b1;
         end else if (r_ready && (r_cnt == CNT_DEADLINE)) begin
            w_underrun = 1'b1;
            w_ready    = 1'b0;
         end

         if (r_cnt == CNT_LAST) begin
            w_cnt  = '0;
            w_load = 1'b1;
            w_idx  = r_idx + 1'b1;
            w_sh   = {r_sh[13:0], 1'b0};
            w_bit  = r_sh[14];
            unique case (r_state)
               S_PRE: begin
                  w_bit = ~w_idx[0];
                  if (r_idx == PRE_LAST) begin
                     w_state = S_SYNC;
                     w_idx   = '0;
                     w_sh    = SYNC_WORD[14:0];
                     w_bit   = SYNC_WORD[15];
                  end
               end
               S_SYNC: begin
                  if (r_idx == SYNC_LAST) begin
                     w_state = S_LEN;
                     w_idx   = '0;
                     w_sh    = {r_len[6:0], 8'h00};
                     w_bit   = r_len[7];
                  end
               end
               S_LEN, S_DATA: begin
                  if ((r_idx == BYTE_PENULT) && (r_left != '0)) begin
                     w_ready = 1'b1;
                  end
                  if (r_idx == BYTE_LAST) begin
                     w_idx = '0;
                     if (r_pf_full) begin
                        w_state   = S_DATA;
                        w_sh      = {r_pf[6:0], 8'h00};
                        w_bit     = r_pf[7];
                        w_pf_full = 1'b0;
                     end else begin
                        w_state = S_TAIL;
                        w_bit   = 1'b0;
                     end
                  end
               end
               S_TAIL: begin
                  w_bit = 1'b0;
                  if (r_idx == TAIL_LAST) begin
                     w_state = S_IDLE;
                     w_idx   = '0;
                     w_load  = 1'b0;
                     w_data  = 1'b0;
                  end
               end
               default: ;
            endcase
         end else begin
            w_cnt = r_cnt + 1'b1;
         end
      end

`ifdef TX_FRAMER_DIFF_EN
      if (w_load) w_data = r_data ^ w_bit;
`else
      if (w_load) w_data = w_bit;
`endif
   end

   assign w_busy     = (r_state != S_IDLE);
   assign busy       = w_busy;
   assign mod_ena    = w_busy;
   assign clk_data   = w_busy && (r_cnt < CNT_HALF);
   assign data       = r_data;
   assign byte_ready = r_ready;
   assign underrun   = r_underrun;

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: frame-position model checked every cycle plus literal frame expectations.
// Honours TX_FRAMER_DIFF_EN the same way the design does.
module tb_tx_framer;

   localparam int DIV  = 8;
   localparam int PRE  = 32;
   localparam int TAIL = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] len = 8'h00;
   logic [7:0] tx_byte = 8'h00;
   logic       byte_valid = 1'b0;
   logic       byte_ready, clk_data, data, mod_ena, busy, underrun;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [15:0] sync_v = 16'hEB90;

   tx_framer #(
      .CLK_DIV      (DIV),
      .PREAMBLE_BITS(PRE),
      .SYNC_WORD    (16'hEB90),
      .TAIL_BITS    (TAIL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .tx_byte   (tx_byte),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .clk_data  (clk_data),
      .data      (data),
      .mod_ena   (mod_ena),
      .busy      (busy),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: outputs derived from frame position ----------------
   bit         m_act = 0, m_ready = 0, m_und = 0, m_abort = 0, m_data = 0;
   int         m_k = 0;
   logic [7:0] m_len = 8'h00;
   logic [7:0] m_bytes[$];

   function automatic logic frame_bit(input int n);
      int p;
      logic [7:0] b;
      p = n;
      if (p < PRE) return (p % 2 == 0);
      p -= PRE;
      if (p < 16) return sync_v[15-p];
      p -= 16;
      if (p < 8) return m_len[7-p];
      p -= 8;
      if (p < 8 * int'(m_len)) begin
         if (p / 8 < m_bytes.size()) begin
            b = m_bytes[p/8];
            return b[7 - p % 8];
         end
         return 1'b0;
      end
      return 1'b0;
   endfunction

   function automatic logic enc(input logic prev, input logic b);
`ifdef TX_FRAMER_DIFF_EN
      return prev ^ b;
`else
      return b;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int n, nbits;
      if (!rst_n) begin
         m_act = 0; m_ready = 0; m_und = 0; m_abort = 0; m_data = 0; m_k = 0;
         m_bytes.delete();
      end else begin
         m_und = 0;
         if (!m_act) begin
            if (start) begin
               m_act = 1; m_k = 0; m_len = len; m_bytes.delete();
               m_ready = 0; m_abort = 0;
               m_data = enc(1'b0, frame_bit(0));
            end
         end else if (m_abort) begin
            m_act = 0; m_abort = 0; m_data = 0; m_ready = 0;
         end else begin
            if (m_ready && byte_valid) begin
               m_bytes.push_back(tx_byte);
               m_ready = 0;
            end else if (m_ready && (m_k % DIV) == DIV - 2) begin
               m_und = 1; m_abort = 1; m_ready = 0;
            end
            m_k++;
            nbits = PRE + 16 + 8 + 8 * int'(m_len) + TAIL;
            if (m_k == nbits * DIV) begin
               m_act = 0; m_data = 0;
            end else if (m_k % DIV == 0) begin
               n = m_k / DIV;
               m_data = enc(m_data, frame_bit(n));
               if (m_bytes.size() < int'(m_len) && n == PRE + 16 + 8 - 1 + 8 * m_bytes.size())
                  m_ready = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle",
               {busy, mod_ena, clk_data, data, byte_ready, underrun},
               {m_act, m_act, m_act && ((m_k % DIV) < DIV / 2), m_data, m_ready, m_und});
      end
   end

   // ---------------- observation statistics ----------------
   int           me_cnt = 0, rdy_rises = 0, und_cnt = 0, und_at = 0;
   logic [127:0] cap_raw = '0, cap_dec = '0;
   logic         p_clk = 0, p_rdy = 0, p_me = 0, p_d = 0;

   always @(negedge clk) begin
      if (mod_ena === 1'b1) begin
         if (p_me !== 1'b1) p_d = 1'b0;
         me_cnt++;
         if (clk_data === 1'b1 && p_clk !== 1'b1) begin
            cap_raw = {cap_raw[126:0], data};
            cap_dec = {cap_dec[126:0], data ^ p_d};
            p_d = data;
         end
      end
      if (byte_ready === 1'b1 && p_rdy !== 1'b1) rdy_rises++;
      if (underrun === 1'b1) begin
         und_cnt++;
         und_at = me_cnt;
      end
      p_clk = clk_data; p_rdy = byte_ready; p_me = mod_ena;
   end

   function automatic logic [127:0] recovered();
`ifdef TX_FRAMER_DIFF_EN
      return cap_dec;
`else
      return cap_raw;
`endif
   endfunction

   int me0, rdy0, und0;
   task automatic snap();
      me0 = me_cnt; rdy0 = rdy_rises; und0 = und_cnt;
   endtask

   task automatic pulse_start(input logic [7:0] l);
      len = l;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      while (busy !== 1'b0 && i < 1000) begin
         @(negedge clk);
         i++;
      end
      check(name, {127'b0, busy}, 128'd0);
   endtask

   logic [7:0] exp_pre8;

   initial begin
`ifdef TX_FRAMER_DIFF_EN
      exp_pre8 = 8'hCC;
`else
      exp_pre8 = 8'hAA;
`endif
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_outputs", {busy, mod_ena, clk_data, data, byte_ready, underrun}, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // nominal frame, byte offered immediately
      snap();
      tx_byte = 8'hA5; byte_valid = 1'b1;
      pulse_start(8'd1);
      check("start_first_cycle", {busy, mod_ena, clk_data, data}, 128'hF);
      wait_idle("nominal_done");
      #1;
      check("nominal_mod_ena_cycles", me_cnt - me0, 128'd576);
      check("nominal_bits", recovered() & {56'b0, {72{1'b1}}}, 128'hAAAAAAAAEB9001A500);
      check("nominal_first8", cap_raw[71:64], exp_pre8);
      check("nominal_ready_rises", rdy_rises - rdy0, 128'd1);
      check("nominal_no_underrun", und_cnt - und0, 128'd0);
      byte_valid = 1'b0;

      // zero length
      snap();
      pulse_start(8'd0);
      wait_idle("zero_done");
      #1;
      check("zero_mod_ena_cycles", me_cnt - me0, 128'd512);
      check("zero_bits", recovered() & {64'b0, {64{1'b1}}}, 128'hAAAAAAAAEB900000);
      check("zero_ready_rises", rdy_rises - rdy0, 128'd0);

      // underrun on the second byte
      snap();
      tx_byte = 8'h3C; byte_valid = 1'b1;
      pulse_start(8'd2);
      for (int i = 0; i < 600 && byte_ready !== 1'b1; i++) @(negedge clk);
      check("underrun_ready_seen", {127'b0, byte_ready}, 128'd1);
      @(negedge clk);
      byte_valid = 1'b0;
      wait_idle("underrun_done");
      #1;
      check("underrun_pulses", und_cnt - und0, 128'd1);
      check("underrun_position", und_at - me0, 128'd512);
      check("underrun_mod_ena_cycles", me_cnt - me0, 128'd512);
      check("underrun_bits", recovered() & {64'b0, {64{1'b1}}}, 128'hAAAAAAAAEB90023C);
      check("underrun_ready_rises", rdy_rises - rdy0, 128'd2);

      // start during SYNC is ignored; start right after busy falls is taken
      snap();
      tx_byte = 8'hA5; byte_valid = 1'b1;
      pulse_start(8'd1);
      repeat (39 * DIV) @(negedge clk);
      pulse_start(8'd5);
      wait_idle("busy_start_done");
      #1;
      check("busy_start_mod_ena_cycles", me_cnt - me0, 128'd576);
      check("busy_start_bits", recovered() & {56'b0, {72{1'b1}}}, 128'hAAAAAAAAEB9001A500);
      byte_valid = 1'b0;
      snap();
      len = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", {127'b0, busy}, 128'd1);
      wait_idle("restart_done");
      #1;
      check("restart_mod_ena_cycles", me_cnt - me0, 128'd512);

      // reset in the middle of DATA
      snap();
      tx_byte = 8'h5A; byte_valid = 1'b1;
      pulse_start(8'd3);
      repeat (60 * DIV) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_outputs", {busy, mod_ena, clk_data, data, byte_ready, underrun}, 128'd0);
      repeat (2) @(negedge clk);
      check("reset_mid_no_underrun", und_cnt - und0, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      snap();
      tx_byte = 8'hC3;
      pulse_start(8'd1);
      wait_idle("after_reset_done");
      #1;
      check("after_reset_mod_ena_cycles", me_cnt - me0, 128'd576);
      check("after_reset_bits", recovered() & {56'b0, {72{1'b1}}}, 128'hAAAAAAAAEB9001C300);
      check("after_reset_ready_rises", rdy_rises - rdy0, 128'd1);
      byte_valid = 1'b0;

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
